// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter shared definitions:
// bus widths, master indices, alignment helper.
`ifndef RAM_ARBITER_DEFS
`define RAM_ARBITER_DEFS
`define ADDR_WIDTH 32
`define DATA_WIDTH 32
`define ZERO '0
`endif

package ram_arbiter_pkg;
  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

  function automatic logic misaligned(
    input logic [1:0] lsb
  );
    return lsb != 2'b00;
  endfunction
endpackage

// File: rtl/ram_arbiter_if.sv
// Per-master request/response bus:
// req/gnt request plus valid/ready response.
interface ram_arbiter_if #(
  parameter int ADDR_W = `ADDR_WIDTH,
  parameter int DATA_W = `DATA_WIDTH
);
  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              gnt_o;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_err_o;
  logic              rsp_ready_i;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    output rsp_ready_i,
    input  gnt_o, rsp_valid_o,
    input  rsp_data_o, rsp_err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    input  rsp_ready_i,
    output gnt_o, rsp_valid_o,
    output rsp_data_o, rsp_err_o
  );
endinterface

// File: rtl/ram_arb_rsp_slot.sv
// One-deep response register per master:
// holds until ready, replaced on a new transfer.
module ram_arb_rsp_slot
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_W = `DATA_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_xfer,
  input  logic              i_rd,
  input  logic              i_err,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_err
);
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= `ZERO;
      r_err   <= 1'b0;
    end else if (i_xfer) begin
      r_valid <= 1'b1;
      r_data  <= i_rd ? i_rdata : `ZERO;
      r_err   <= i_err;
    end else if (i_ready && r_valid) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_err   = r_err;
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin share of the data RAM
// between instruction fetch and LSU.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = `ADDR_WIDTH,
  parameter int DATA_W = `DATA_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ram_arbiter_if.slave      m0,
  ram_arbiter_if.slave      m1,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);
  logic r_ptr;
  logic w_el0, w_el1;
  logic w_gnt0, w_gnt1;
  logic w_mis0, w_mis1;

  assign w_mis0 = misaligned(m0.addr_i[1:0]);
  assign w_mis1 = misaligned(m1.addr_i[1:0]);

  // a master whose response leaves this cycle may re-issue
  assign w_el0 = m0.req_i &
    (~m0.rsp_valid_o | m0.rsp_ready_i);
  assign w_el1 = m1.req_i &
    (~m1.rsp_valid_o | m1.rsp_ready_i);

  assign w_gnt0 = ~rst_i & w_el0 &
    (~w_el1 | (r_ptr == M_IFU));
  assign w_gnt1 = ~rst_i & w_el1 &
    (~w_el0 | (r_ptr == M_LSU));

  assign m0.gnt_o = w_gnt0;
  assign m1.gnt_o = w_gnt1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       r_ptr <= M_IFU;
    else if (w_gnt0) r_ptr <= M_LSU;
    else if (w_gnt1) r_ptr <= M_IFU;
  end

  always_comb begin
    ram_addr_o  = m0.addr_i;
    ram_wdata_o = m0.wdata_i;
    ram_we_o    = 1'b0;
    unique case (1'b1)
      w_gnt1: begin
        ram_addr_o  = m1.addr_i;
        ram_wdata_o = m1.wdata_i;
        ram_we_o    = m1.we_i & ~w_mis1;
      end
      w_gnt0: begin
        ram_we_o    = m0.we_i & ~w_mis0;
      end
      default: ;
    endcase
  end

  ram_arb_rsp_slot #(.DATA_W(DATA_W)) u_slot0 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_xfer  (w_gnt0),
    .i_rd    (~m0.we_i & ~w_mis0),
    .i_err   (w_mis0),
    .i_rdata (ram_rdata_i),
    .i_ready (m0.rsp_ready_i),
    .o_valid (m0.rsp_valid_o),
    .o_data  (m0.rsp_data_o),
    .o_err   (m0.rsp_err_o)
  );

  ram_arb_rsp_slot #(.DATA_W(DATA_W)) u_slot1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_xfer  (w_gnt1),
    .i_rd    (~m1.we_i & ~w_mis1),
    .i_err   (w_mis1),
    .i_rdata (ram_rdata_i),
    .i_ready (m1.rsp_ready_i),
    .o_valid (m1.rsp_valid_o),
    .o_data  (m1.rsp_data_o),
    .o_err   (m1.rsp_err_o)
  );
endmodule
